// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending word stores with youngest-match load forwarding.
// Optional feature macro STORE_BUF_COALESCE_EN: merge a store into the youngest entry on address match.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_hit,
    output logic                     ld_stall,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic [PW-1:0]    age_idx [DEPTH];
    logic             full;
    logic             load_mem;
    logic             drain;
    logic             push;
    logic             push_new;
    logic             coalesce;
    logic             fwd_hit;
    logic [DW-1:0]    fwd_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Slot index of the i-th oldest entry
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_idx[i] = head_q + PW'(i);
        end
    end

    // Oldest-to-youngest scan so the last match found is the youngest
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[age_idx[i]] && (addr_q[age_idx[i]] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[age_idx[i]];
            end
        end
    end

    assign ld_hit   = fwd_hit;
    assign ld_data  = fwd_hit ? fwd_data : mem_rdata;
    assign load_mem = ld_valid & ~fwd_hit;
    // A full buffer takes the port from a missing load so stores always make progress
    assign drain    = ~empty & (~load_mem | full);
    assign mem_re   = load_mem & ~full;
    assign ld_stall = load_mem & full;
    assign mem_we   = drain;
    assign mem_addr = drain ? addr_q[head_q] : ld_addr;
    assign mem_wdata = data_q[head_q];

`ifdef STORE_BUF_COALESCE_EN
    logic [PW-1:0] youngest;
    assign youngest = tail_q - PW'(1);
    // The youngest entry leaving this cycle cannot absorb the store
    assign coalesce = ~empty & valid_q[youngest] & (addr_q[youngest] == st_addr)
                    & ~(drain & (youngest == head_q));
    assign st_ready = ~full | coalesce;
`else
    assign coalesce = 1'b0;
    assign st_ready = ~full;
`endif

    assign push     = st_valid & st_ready;
    assign push_new = push & ~coalesce;

    // Pointers, occupancy and valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (push_new) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
            count_q <= count_q + CW'(push_new) - CW'(drain);
        end
    end

    // Payload storage; contents are only meaningful under a set valid bit
    always_ff @(posedge clk) begin
        if (push_new) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
`ifdef STORE_BUF_COALESCE_EN
        else if (push) begin
            data_q[youngest] <= st_data;
        end
`endif
    end

endmodule
